// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache with zero-latency hits and a word-by-word line refill
// from backing memory over a req/ack handshake; supports a whole-cache flush.
module icache_refill_ctrl #(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_instr,
    output logic        fetch_valid,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int WB = $clog2(WORDS_PER_LINE);
    localparam int OB = WB + 2;
    localparam int IB = $clog2(LINES);
    localparam int TW = 32 - OB - IB;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [LINES-1:0] r_valid;
    logic [TW-1:0]    r_tag  [LINES];
    logic [31:0]      r_data [LINES][WORDS_PER_LINE];
    logic [31:OB]     r_lineHi;
    logic [WB-1:0]    r_beat;
    logic             r_flushPend;

    logic [TW-1:0] w_tag;
    logic [IB-1:0] w_idx;
    logic [WB-1:0] w_word;
    logic [IB-1:0] w_fillIdx;
    logic [TW-1:0] w_fillTag;
    logic          w_hit;
    logic          w_miss;
    logic          w_beatDone;
    logic          w_lastBeat;
    logic          w_unused;

    assign w_tag      = fetch_addr[31:OB+IB];
    assign w_idx      = fetch_addr[OB+IB-1:OB];
    assign w_word     = fetch_addr[OB-1:2];
    assign w_fillIdx  = r_lineHi[OB+IB-1:OB];
    assign w_fillTag  = r_lineHi[31:OB+IB];
    assign w_lastBeat = (r_beat == WB'(WORDS_PER_LINE - 1));
    assign w_unused   = &{1'b0, fetch_addr[1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Hits are only answered in IDLE; during a refill every fetch stalls.
    always_comb begin
        w_nextState = r_state;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_beatDone  = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        fetch_valid = 1'b0;
        fetch_instr = '0;
        stall       = 1'b0;
        case (r_state)
            IDLE: begin
                w_hit  = fetch_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
                w_miss = fetch_req && !w_hit;
                if (w_miss) begin
                    w_nextState = REFILL;
                end
            end
            REFILL: begin
                mem_req    = 1'b1;
                mem_addr   = {r_lineHi, r_beat, 2'b00};
                w_beatDone = mem_ack;
                if (w_beatDone && w_lastBeat) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
        fetch_valid = w_hit;
        stall       = fetch_req && !w_hit;
        if (w_hit) begin
            fetch_instr = r_data[w_idx][w_word];
        end
    end

    always_ff @(posedge clock) begin
        if (w_beatDone) begin
            r_data[w_fillIdx][r_beat] <= mem_rdata;
            if (w_lastBeat) begin
                r_tag[w_fillIdx] <= w_fillTag;
            end
        end
    end

    // A flush seen during a refill is deferred so the completing line is not left valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid     <= '0;
            r_lineHi    <= '0;
            r_beat      <= '0;
            r_flushPend <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_miss) begin
                r_lineHi       <= fetch_addr[31:OB];
                r_beat         <= '0;
                r_valid[w_idx] <= 1'b0;
            end
            if (flush) begin
                r_valid <= '0;
            end
        end else begin
            if (flush) begin
                r_flushPend <= 1'b1;
            end
            if (w_beatDone) begin
                r_beat <= r_beat + WB'(1);
                if (w_lastBeat) begin
                    r_flushPend <= 1'b0;
                    if (flush || r_flushPend) begin
                        r_valid <= '0;
                    end else begin
                        r_valid[w_fillIdx] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Direct-mapped instruction cache controller between the fetch stage and a word-wide backing instruction memory. It holds tag, valid and data arrays and answers fetch hits combinationally. On a miss it stalls fetch and runs a line-refill FSM that streams one line from backing memory over a req/ack handshake. It also provides a whole-cache flush for use after instruction-memory writes.

Parameters:
LINES, 8, number of cache lines (power of 2, ≥2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
fetch_req  in  1  fetch stage requests the instruction at fetch_addr
fetch_addr  in  32  byte address; bits[1:0] ignored
fetch_instr  out  32  instruction word; 0 when fetch_valid=0
fetch_valid  out  1  fetch_instr is valid this cycle (hit)
stall  out  1  fetch must hold fetch_addr and retry
flush  in  1  single-cycle pulse: invalidate all lines
mem_req  out  1  refill beat request, held until acked
mem_addr  out  32  word-aligned byte address of the requested beat
mem_ack  in  1  beat accepted; mem_rdata is valid this cycle
mem_rdata  in  32  refill data

Behaviour:
- Address split: offset = bits[OB-1:0], with OB = log2(WORDS_PER_LINE)+2. Index = next log2(LINES) bits. Tag = remaining upper bits.
- States: IDLE, REFILL.
- Reset (async): state=IDLE, all valid bits=0, mem_req=0, mem_addr=0, beat counter=0, pending-flush=0. Data and tag arrays are not reset.
- Hit, combinational: hit = (state==IDLE) & fetch_req & valid[index] & (tag[index]==tag). On a hit: fetch_valid=1, fetch_instr=data[index][word], stall=0. Zero-latency hit.
- stall = fetch_req & ~hit.
- Miss in IDLE:
  - On the clock edge, latch the line base (fetch_addr with offset bits cleared) and clear valid[index].
  - Go to REFILL with beat counter=0.
- REFILL:
  - mem_req=1 and mem_addr=base+4*beat.
  - A beat completes on an edge where mem_req & mem_ack: write mem_rdata into data[index][beat], then increment beat.
  - mem_ack is legal in the first cycle mem_req is high.
  - mem_ack while mem_req=0 is ignored.
  - After the last beat's edge: write the tag, set valid[index]=1, go to IDLE, mem_req=0.
  - The next cycle hits, provided fetch_addr is unchanged.
- Refill latency with mem_ack always high: miss cycle + WORDS_PER_LINE beats. That is 5 stall cycles for the default, with the hit on the 6th cycle.
- During REFILL, fetch_addr changes are ignored and the refill completes for the latched line. The new address is evaluated in IDLE.
- Flush:
  - In IDLE: all valid bits are cleared on the edge, and the same cycle's hit logic still uses the pre-flush valids.
  - During REFILL: the flush is latched as pending. At refill completion all valid bits, including the just-filled line, are cleared instead of setting the line valid. Pending is then cleared.
- Flush coinciding with a miss in IDLE: the flush applies and the refill starts normally.
- Reset mid-refill: mem_req drops immediately (async), the partial line stays invalid, and the FSM returns to IDLE.
- No speculative or critical-word-first fetch. Beats are always issued in ascending order from the line base.

Test Plan:
- Cold miss, fetch_addr=0x0000_0004, mem_ack tied high, mem_rdata=mem_addr+0x100 → mem_addr 0x0,0x4,0x8,0xC on consecutive cycles. stall high 5 cycles. Cycle 6: fetch_valid=1, fetch_instr=0x104.
- Sequential hits after the fill: fetch_addr 0x0,0x8,0xC back-to-back → fetch_valid=1 each cycle with 0x100,0x108,0x10C, mem_req stays 0.
- Conflict eviction (defaults, 128-byte cache): fill 0x00, then fetch 0x80 → miss and refill of 0x80..0x8C. Re-fetch of 0x00 → miss again.
- Backpressure: mem_ack high only every 3rd cycle → mem_addr held stable while unacked, each beat written once, 13 stall cycles total.
- Flush: pulse flush in IDLE after a fill → next fetch of 0x0 misses. Pulse flush mid-REFILL → line not valid after completion, next fetch to it refills again.
- Reset mid-refill after 2 beats: assert reset → mem_req=0 immediately. After release, fetch 0x4 → fresh refill starting at mem_addr 0x0.
